div_radix2: RTL and testbench

//  Multi-cycle 32-bit signed/unsigned divider for MIPS DIV/DIVU in the execute stage.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_radix2_if.sv | 27 ++
 rtl/div_step.sv | 24 ++
 rtl/div_radix2.sv | 121 ++++++++++++
 tb/tb_div_radix2.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared divider definitions: state encoding and width constants, also used by
// the hazard unit and the HI/LO register.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_radix2_if.sv
// Execute-stage divide request/response bundle between the pipeline and the divider.
interface div_radix2_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             startE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             annulE;
    logic             longest_stall;
    logic             stall_divE;
    logic             ready;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output startE, signedE, srcaE, srcbE, annulE, longest_stall,
        input  stall_divE, ready, hi_out, lo_out
    );

    modport slave (
        input  startE, signedE, srcaE, srcbE, annulE, longest_stall,
        output stall_divE, ready, hi_out, lo_out
    );
endinterface

// File: rtl/div_step.sv
// One restoring radix-2 step: shift {rem,quo} left, subtract divisor if it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic [WIDTH-1:0] quo_next_c
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // The true difference is below the divisor when it fits, so WIDTH-bit
    // modular subtraction is exact.
    always_comb begin
        shifted    = {rem, quo[WIDTH-1]};
        fits       = (shifted >= {1'b0, divisor});
        diff       = shifted[WIDTH-1:0] - divisor;
        rem_next_c = fits ? diff : shifted[WIDTH-1:0];
        quo_next_c = {quo[WIDTH-2:0], fits};
    end
endmodule

// File: rtl/div_radix2.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU; holds the pipeline while busy
// and returns {hi=remainder, lo=quotient}.
module div_radix2
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic         clk,
    input logic         rst,
    div_radix2_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic             a_neg, b_neg;

    // Two's-complement negation of the most negative value yields exactly 2^(WIDTH-1)
    // when read as unsigned, so the magnitude needs no extra bit in storage.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem        (rem_q),
        .quo        (quo_q),
        .divisor    (dvs_q),
        .rem_next_c (step_rem),
        .quo_next_c (step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    // Next-state, iteration and result capture with sign fix on the final step.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        a_neg   = bus.signedE & bus.srcaE[WIDTH-1];
        b_neg   = bus.signedE & bus.srcbE[WIDTH-1];

        unique case (state_q)
            S_IDLE: begin
                if (bus.startE) begin
                    state_d = S_BUSY;
                    count_d = '0;
                    rem_d   = '0;
                    quo_d   = magnitude(bus.srcaE, a_neg);
                    dvs_d   = magnitude(bus.srcbE, b_neg);
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                end
            end
            S_BUSY: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    lo_d    = magnitude(step_quo, q_neg_q);
                    hi_d    = magnitude(step_rem, r_neg_q);
                end
            end
            S_DONE: begin
                if (!bus.longest_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Annul abandons any divide and keeps the previously delivered result.
        if (bus.annulE) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    assign bus.stall_divE = ~bus.annulE &
                            (((state_q == S_IDLE) & bus.startE) | (state_q == S_BUSY));
    assign bus.ready      = ~bus.annulE & (state_q == S_DONE);
    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;
endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: latency, signed/unsigned results, annul, hold and reset.
module tb_div_radix2;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    div_radix2_if bus ();

    div_radix2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Caller is just past a rising edge; returns at the falling edge of the DONE cycle.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
        int cyc    = 0;
        int stalls = 0;
        bit seen   = 1'b0;
        bus.signedE = sgn;
        bus.srcaE   = a;
        bus.srcbE   = b;
        bus.startE  = 1'b1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.stall_divE) stalls++;
            if (bus.ready) seen = 1'b1;
        end
        check({tag, "_ready"}, 32'(seen), 32'd1);
        check({tag, "_lo"}, bus.lo_out, exp_lo);
        check({tag, "_hi"}, bus.hi_out, exp_hi);
        check({tag, "_cycles"}, 32'(cyc), 32'd34);
        check({tag, "_stalls"}, 32'(stalls), 32'd33);
        check({tag, "_done_stall"}, 32'(bus.stall_divE), 32'd0);
    endtask

    // Instruction leaves E after DONE: drop startE and confirm idle with result held.
    task automatic release_div(input string tag, input logic [31:0] exp_lo,
                               input logic [31:0] exp_hi);
        @(posedge clk);
        #1;
        bus.startE = 1'b0;
        @(negedge clk);
        check({tag, "_rel_ready"}, 32'(bus.ready), 32'd0);
        check({tag, "_rel_stall"}, 32'(bus.stall_divE), 32'd0);
        check({tag, "_rel_lo"}, bus.lo_out, exp_lo);
        check({tag, "_rel_hi"}, bus.hi_out, exp_hi);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ready_seen;
        rst               = 1'b1;
        bus.startE        = 1'b0;
        bus.signedE       = 1'b0;
        bus.srcaE         = '0;
        bus.srcbE         = '0;
        bus.annulE        = 1'b0;
        bus.longest_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_stall", 32'(bus.stall_divE), 32'd0);
        check("rst_lo", bus.lo_out, 32'd0);
        check("rst_hi", bus.hi_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic unsigned, signed sign rules, boundaries.
        @(posedge clk); #1;
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        release_div("divu_100_7", 32'd14, 32'd2);
        @(posedge clk); #1;
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        release_div("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        release_div("div_7_m2", 32'hFFFF_FFFD, 32'd1);
        @(posedge clk); #1;
        do_div("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFE);
        release_div("div_m8_m3", 32'd2, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, ALL_ONES, 32'd0);
        release_div("divu_max_1", ALL_ONES, 32'd0);
        @(posedge clk); #1;
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        release_div("div_min_m1", 32'h8000_0000, 32'd0);
        @(posedge clk); #1;
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, ALL_ONES, 32'd5);
        release_div("divu_5_0", ALL_ONES, 32'd5);

        // Annul at BUSY count=10, then a clean restart.
        @(posedge clk); #1;
        bus.signedE = 1'b0;
        bus.srcaE   = 32'd100;
        bus.srcbE   = 32'd7;
        bus.startE  = 1'b1;
        ready_seen  = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (bus.ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("annul_busy_stall", 32'(bus.stall_divE), 32'd1);
        bus.annulE = 1'b1;
        #1;
        check("annul_stall", 32'(bus.stall_divE), 32'd0);
        check("annul_ready", 32'(bus.ready), 32'd0);
        @(posedge clk); #1;
        bus.annulE = 1'b0;
        bus.startE = 1'b0;
        @(negedge clk);
        check("annul_idle_stall", 32'(bus.stall_divE), 32'd0);
        check("annul_idle_ready", 32'(bus.ready), 32'd0);
        check("annul_never_ready", 32'(ready_seen), 32'd0);
        check("annul_lo_held", bus.lo_out, ALL_ONES);
        check("annul_hi_held", bus.hi_out, 32'd5);
        @(posedge clk); #1;
        do_div("after_annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        release_div("after_annul", 32'd14, 32'd2);

        // longest_stall held for the first three DONE cycles.
        @(posedge clk); #1;
        bus.signedE = 1'b0;
        bus.srcaE   = 32'd1000;
        bus.srcbE   = 32'd33;
        bus.startE  = 1'b1;
        repeat (33) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            bus.longest_stall = (i < 3);
            @(negedge clk);
            check($sformatf("hold%0d_ready", i), 32'(bus.ready), 32'd1);
            check($sformatf("hold%0d_stall", i), 32'(bus.stall_divE), 32'd0);
            check($sformatf("hold%0d_lo", i), bus.lo_out, 32'd30);
            check($sformatf("hold%0d_hi", i), bus.hi_out, 32'd10);
            @(posedge clk);
            #1;
        end
        bus.startE = 1'b0;
        @(negedge clk);
        check("hold_end_ready", 32'(bus.ready), 32'd0);
        check("hold_end_stall", 32'(bus.stall_divE), 32'd0);

        // Back-to-back divides with startE never dropping in between.
        @(posedge clk); #1;
        do_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
        @(posedge clk); #1;
        do_div("b2b_10_4", 1'b0, 32'd10, 32'd4, 32'd2, 32'd2);
        release_div("b2b_10_4", 32'd2, 32'd2);

        // Reset mid-divide discards the divide and clears results.
        @(posedge clk); #1;
        bus.srcaE  = 32'd9;
        bus.srcbE  = 32'd3;
        bus.startE = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.startE = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_stall", 32'(bus.stall_divE), 32'd0);
        check("mid_rst_ready", 32'(bus.ready), 32'd0);
        check("mid_rst_lo", bus.lo_out, 32'd0);
        check("mid_rst_hi", bus.hi_out, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
